// File: rtl/serial_word_demux.sv
// serial_word_demux: reassembles a 16-slot serial bit stream (slot k -> word[k])
// into a word presented on a valid/ready output, with a nibble view of that word.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both 1. A producer holding valid=1 keeps its data stable
// until the transfer; ready may depend on state only, never on the same-cycle
// valid, so there is no combinational path from in_* to out_* or back.
module serial_word_demux #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_start,
    input  logic             in_bit,
    output logic             in_ready,
    output logic [SEL_W-1:0] sel_out,
    output logic [WIDTH-1:0] word_out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [1:0]       nib_sel,
    output logic [3:0]       nib_out,
    output logic             frame_err,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] asm_next;
    logic             accept;
    logic             out_free;

    // HOLD is the only state in which the assembly register is occupied by a
    // finished frame, so it is the only state that back-pressures the link.
    assign in_ready  = (state != HOLD);
    assign accept    = in_valid && in_ready;
    assign out_free  = !out_valid || out_ready;
    assign state_dbg = state;

    // Nibble view taken straight from the output register.
    assign nib_out = word_out[{nib_sel, 2'b00} +: 4];

    // Assembly contents with the current beat merged in at the current slot.
    always_comb begin
        asm_next = asm_q;
        asm_next[sel_out] = in_bit;
    end

    // Frame assembly FSM, output register and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel_out   <= '0;
            asm_q     <= '0;
            word_out  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // A consumed word empties the output register unless a new frame
            // loads it on this same edge (overridden below).
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    // Only a frame-start beat opens a frame; anything else is dropped.
                    if (accept && in_start) begin
                        asm_q   <= WIDTH'(in_bit);
                        sel_out <= SEL_W'(1);
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (in_start && (sel_out != '0)) begin
                            // Early start: drop the partial frame and restart on this beat.
                            frame_err <= 1'b1;
                            asm_q     <= WIDTH'(in_bit);
                            sel_out   <= SEL_W'(1);
                        end else if (sel_out == LAST_SLOT) begin
                            sel_out <= '0;
                            if (out_free) begin
                                word_out  <= asm_next;
                                out_valid <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                // Output register still owned by the consumer: park the frame.
                                asm_q <= asm_next;
                                state <= HOLD;
                            end
                        end else begin
                            asm_q   <= asm_next;
                            sel_out <= sel_out + SEL_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // The parked frame follows the consumed one straight away.
                    if (out_valid && out_ready) begin
                        word_out  <= asm_q;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_demux.sv
// tb_serial_word_demux: directed checks of frame assembly, back-pressure,
// early-start abort, mid-frame reset and dropped idle beats.
module tb_serial_word_demux;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_start;
    logic        in_bit;
    logic        in_ready;
    logic [3:0]  sel_out;
    logic [15:0] word_out;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  nib_sel;
    logic [3:0]  nib_out;
    logic        frame_err;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    serial_word_demux #(.WIDTH(16), .SEL_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_start  (in_start),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .sel_out   (sel_out),
        .word_out  (word_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .nib_sel   (nib_sel),
        .nib_out   (nib_out),
        .frame_err (frame_err),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic b, input logic s);
        in_valid = 1'b1;
        in_bit   = b;
        in_start = s;
        tick();
        in_valid = 1'b0;
        in_start = 1'b0;
        in_bit   = 1'b0;
    endtask

    // Send a full frame, checking sel_out before every beat and across idle gaps.
    task automatic send_frame(input logic [15:0] w, input bit gaps);
        for (int k = 0; k < 16; k++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 2);
                for (int g = 0; g < n; g++) begin
                    tick();
                    check("gap_sel", 32'(sel_out), 32'(k));
                end
            end
            check("pre_sel", 32'(sel_out), 32'(k));
            beat(w[k], (k == 0));
        end
        exp_q.push_back(w);
    endtask

    // Scoreboard: compare the visible word with the oldest expected frame.
    task automatic expect_word(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_empty_q"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(word_out), 32'(e));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_start = 1'b0; in_bit = 1'b0;
        out_ready = 1'b1; nib_sel = 2'd0;
        #2;
        do_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sel", 32'(sel_out), 32'd0);
        check("rst_word", 32'(word_out), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);

        // T1: contiguous frame A3F1
        out_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            check("t1_sel", 32'(sel_out), 32'(k));
            beat(1'(16'hA3F1 >> k), (k == 0));
        end
        check("t1_not_yet", 32'(out_valid), 32'd0);
        check("t1_sel15", 32'(sel_out), 32'd15);
        beat(1'b1, 1'b0);
        exp_q.push_back(16'hA3F1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_sel_wrap", 32'(sel_out), 32'd0);
        check("t1_err", 32'(frame_err), 32'd0);
        nib_sel = 2'd0; #1; check("t1_nib0", 32'(nib_out), 32'h1);
        nib_sel = 2'd1; #1; check("t1_nib1", 32'(nib_out), 32'hF);
        nib_sel = 2'd2; #1; check("t1_nib2", 32'(nib_out), 32'h3);
        nib_sel = 2'd3; #1; check("t1_nib3", 32'(nib_out), 32'hA);
        expect_word("t1_word");
        tick();
        check("t1_consumed", 32'(out_valid), 32'd0);

        // T2: same frame with idle gaps
        send_frame(16'hA3F1, 1'b1);
        check("t2_valid", 32'(out_valid), 32'd1);
        expect_word("t2_word");
        tick();
        check("t2_consumed", 32'(out_valid), 32'd0);

        // T3: back-pressure, two frames buffered, delivered in order
        out_ready = 1'b0;
        send_frame(16'hA3F1, 1'b0);
        check("t3_v1", 32'(out_valid), 32'd1);
        send_frame(16'h5C0E, 1'b0);
        check("t3_ready_low", 32'(in_ready), 32'd0);
        check("t3_state_hold", 32'(state_dbg), 32'd2);
        tick();
        check("t3_still_ready_low", 32'(in_ready), 32'd0);
        expect_word("t3_first");
        out_ready = 1'b1;
        tick();
        check("t3_v2", 32'(out_valid), 32'd1);
        check("t3_ready_back", 32'(in_ready), 32'd1);
        expect_word("t3_second");
        tick();
        check("t3_drained", 32'(out_valid), 32'd0);

        // T4: early start at slot 7, then frame 1234
        for (int k = 0; k < 7; k++) beat(1'b1, (k == 0));
        check("t4_sel7", 32'(sel_out), 32'd7);
        beat(1'b0, 1'b1);
        check("t4_err_pulse", 32'(frame_err), 32'd1);
        check("t4_sel_restart", 32'(sel_out), 32'd1);
        for (int k = 1; k < 16; k++) begin
            beat(1'(16'h1234 >> k), 1'b0);
            if (k == 1) check("t4_err_clear", 32'(frame_err), 32'd0);
        end
        exp_q.push_back(16'h1234);
        check("t4_valid", 32'(out_valid), 32'd1);
        expect_word("t4_word");
        tick();

        // T5: reset at slot 9
        for (int k = 0; k < 9; k++) beat(1'(16'hA3F1 >> k), (k == 0));
        check("t5_sel9", 32'(sel_out), 32'd9);
        rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_sel", 32'(sel_out), 32'd0);
        check("t5_word", 32'(word_out), 32'd0);
        send_frame(16'hA3F1, 1'b0);
        check("t5_valid2", 32'(out_valid), 32'd1);
        expect_word("t5_word2");
        tick();

        // T6: beats without start while idle are dropped
        for (int k = 0; k < 3; k++) begin
            beat(1'b1, 1'b0);
            check("t6_sel", 32'(sel_out), 32'd0);
            check("t6_valid", 32'(out_valid), 32'd0);
            check("t6_state", 32'(state_dbg), 32'd0);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
